// File: rtl/alu_pipe.sv
// Registered-output execute ALU: eight single-cycle ops plus an optional
// WIDTH-step shift-add multiply, with valid/ready handshakes on both sides.
module alu_pipe #(
   parameter int WIDTH  = 8,
   parameter int MUL_EN = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] num1,
   input  logic [WIDTH-1:0] num2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] alu_res,
   output logic             zero_flag,
   output logic             carry_flag,
   output logic             overflow_flag,
   output logic             busy
);

   localparam int SW = $clog2(WIDTH);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int PW = 2 * WIDTH;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_SLT = 4'd5;
   localparam logic [3:0] OP_SHL = 4'd6;
   localparam logic [3:0] OP_SHR = 4'd7;
   localparam logic [3:0] OP_MUL = 4'd8;

   typedef enum logic {S_IDLE, S_MUL} state_e;

   state_e           state_q, state_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             zero_q, zero_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic [PW-1:0]    mcand_q, mcand_d;
   logic [PW-1:0]    acc_q, acc_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             accept;
   logic             is_mul;
   logic [WIDTH:0]   sum_c;
   logic [WIDTH:0]   diff_c;
   logic [SW-1:0]    shamt;
   logic [WIDTH-1:0] alu_res_c;
   logic             alu_carry_c;
   logic             alu_ovf_c;
   logic [PW-1:0]    acc_step_c;

   // in_ready must not see the operands, so it is built from state and the
   // output handshake only.
   assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign is_mul   = (MUL_EN != 0) && (op == OP_MUL);

   // Single-cycle datapath. An opcode 8 that reaches here means the
   // multiplier is disabled and it falls into the illegal (all-zero) case.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves
      // it unassigned, which would otherwise infer a latch.
      alu_res_c   = '0;
      alu_carry_c = 1'b0;
      alu_ovf_c   = 1'b0;
      sum_c       = {1'b0, num1} + {1'b0, num2};
      diff_c      = {1'b0, num1} - {1'b0, num2};
      shamt       = num2[SW-1:0];
      case (op)
         OP_ADD: begin
            alu_res_c   = sum_c[WIDTH-1:0];
            alu_carry_c = sum_c[WIDTH];
            alu_ovf_c   = (num1[WIDTH-1] == num2[WIDTH-1]) &&
                          (sum_c[WIDTH-1] != num1[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res_c   = diff_c[WIDTH-1:0];
            alu_carry_c = diff_c[WIDTH];
            alu_ovf_c   = (num1[WIDTH-1] != num2[WIDTH-1]) &&
                          (diff_c[WIDTH-1] != num1[WIDTH-1]);
         end
         OP_AND: alu_res_c = num1 & num2;
         OP_OR:  alu_res_c = num1 | num2;
         OP_XOR: alu_res_c = num1 ^ num2;
         OP_SLT: alu_res_c = {{(WIDTH-1){1'b0}}, ($signed(num1) < $signed(num2))};
         OP_SHL: alu_res_c = num1 << shamt;
         OP_SHR: alu_res_c = num1 >> shamt;
         default: ;
      endcase
   end

   assign acc_step_c = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

   // Next-state and result-register logic. Results only load on an accept or
   // on the last multiply step; otherwise they hold while out_valid waits.
   always_comb begin
      state_d     = state_q;
      out_valid_d = out_valid_q && !out_ready;
      res_d       = res_q;
      zero_d      = zero_q;
      carry_d     = carry_q;
      ovf_d       = ovf_q;
      mcand_d     = mcand_q;
      acc_d       = acc_q;
      mplier_d    = mplier_q;
      cnt_d       = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (is_mul) begin
                  mcand_d  = {{WIDTH{1'b0}}, num1};
                  mplier_d = num2;
                  acc_d    = '0;
                  cnt_d    = '0;
                  state_d  = S_MUL;
               end else begin
                  res_d       = alu_res_c;
                  zero_d      = (alu_res_c == '0);
                  carry_d     = alu_carry_c;
                  ovf_d       = alu_ovf_c;
                  out_valid_d = 1'b1;
               end
            end
         end
         S_MUL: begin
            acc_d    = acc_step_c;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               res_d       = acc_step_c[WIDTH-1:0];
               zero_d      = (acc_step_c[WIDTH-1:0] == '0);
               carry_d     = |acc_step_c[PW-1:WIDTH];
               ovf_d       = 1'b0;
               out_valid_d = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state is updated only with non-blocking assignments so every flop
   // samples its _d value from before the edge, regardless of block order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         out_valid_q <= 1'b0;
         res_q       <= '0;
         zero_q      <= 1'b0;
         carry_q     <= 1'b0;
         ovf_q       <= 1'b0;
         mcand_q     <= '0;
         acc_q       <= '0;
         mplier_q    <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         res_q       <= res_d;
         zero_q      <= zero_d;
         carry_q     <= carry_d;
         ovf_q       <= ovf_d;
         mcand_q     <= mcand_d;
         acc_q       <= acc_d;
         mplier_q    <= mplier_d;
         cnt_q       <= cnt_d;
      end
   end

   assign out_valid     = out_valid_q;
   assign alu_res       = res_q;
   assign zero_flag     = zero_q;
   assign carry_flag    = carry_q;
   assign overflow_flag = ovf_q;
   assign busy          = (state_q == S_MUL);

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe (WIDTH=8): vector table through a result scoreboard,
// plus hand sequences for multiply latency, back-pressure and reset abort.
module tb_alu_pipe;

   localparam int WIDTH = 8;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_SLT = 4'd5;
   localparam logic [3:0] OP_SHL = 4'd6;
   localparam logic [3:0] OP_SHR = 4'd7;
   localparam logic [3:0] OP_MUL = 4'd8;

   typedef struct packed {
      logic [7:0] res;
      logic       c;
      logic       o;
      logic       z;
   } exp_t;

   typedef struct {
      logic [3:0] op;
      logic [7:0] a;
      logic [7:0] b;
      exp_t       e;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_valid0 = 1'b0;
   logic [3:0] op = 4'd0;
   logic [7:0] num1 = 8'd0;
   logic [7:0] num2 = 8'd0;
   logic       out_ready = 1'b0;

   logic       in_ready, out_valid, zero_flag, carry_flag, overflow_flag, busy;
   logic [7:0] alu_res;
   logic       in_ready0, out_valid0, zero0, carry0, ovf0, busy0;
   logic [7:0] alu_res0;

   int   n_checks = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   n_res = 0;
   exp_t exp_q[$];
   int   pop_cyc[$];

   alu_pipe #(.WIDTH(WIDTH), .MUL_EN(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .num1(num1), .num2(num2), .out_valid(out_valid), .out_ready(out_ready),
      .alu_res(alu_res), .zero_flag(zero_flag), .carry_flag(carry_flag),
      .overflow_flag(overflow_flag), .busy(busy)
   );

   alu_pipe #(.WIDTH(WIDTH), .MUL_EN(0)) dut_nomul (
      .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .op(op),
      .num1(num1), .num2(num2), .out_valid(out_valid0), .out_ready(out_ready),
      .alu_res(alu_res0), .zero_flag(zero0), .carry_flag(carry0),
      .overflow_flag(ovf0), .busy(busy0)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   // Scoreboard: a result is consumed on the edge following a negedge where
   // out_valid && out_ready.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", exp_q.size(), 1);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check($sformatf("result#%0d", n_res),
                  {21'b0, alu_res, carry_flag, overflow_flag, zero_flag}, {21'b0, e});
            n_res++;
            pop_cyc.push_back(cyc);
         end
      end
   end

   // Presents one request and returns just after the accept edge.
   task automatic send(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                       input exp_t e, input bit push);
      int n;
      op = o;
      num1 = a;
      num2 = b;
      in_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 50);
      if (!in_ready) begin
         check("accept_timeout", {31'b0, in_ready}, 1);
         in_valid = 1'b0;
         return;
      end
      if (push) exp_q.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("drain", exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   vec_t vecs[18];

   initial begin
      int edges;
      int bad;
      int np;

      vecs[0]  = '{OP_ADD, 8'd200, 8'd100, '{8'd44,  1'b1, 1'b0, 1'b0}};
      vecs[1]  = '{OP_ADD, 8'd127, 8'd1,   '{8'd128, 1'b0, 1'b1, 1'b0}};
      vecs[2]  = '{OP_ADD, 8'hFF,  8'h01,  '{8'd0,   1'b1, 1'b0, 1'b1}};
      vecs[3]  = '{OP_SUB, 8'd5,   8'd5,   '{8'd0,   1'b0, 1'b0, 1'b1}};
      vecs[4]  = '{OP_SUB, 8'd3,   8'd5,   '{8'd254, 1'b1, 1'b0, 1'b0}};
      vecs[5]  = '{OP_SUB, 8'h80,  8'h01,  '{8'h7F,  1'b0, 1'b1, 1'b0}};
      vecs[6]  = '{OP_AND, 8'hF0,  8'h3C,  '{8'h30,  1'b0, 1'b0, 1'b0}};
      vecs[7]  = '{OP_OR,  8'hF0,  8'h0F,  '{8'hFF,  1'b0, 1'b0, 1'b0}};
      vecs[8]  = '{OP_XOR, 8'hAA,  8'hFF,  '{8'h55,  1'b0, 1'b0, 1'b0}};
      vecs[9]  = '{OP_SLT, 8'hFF,  8'h01,  '{8'h01,  1'b0, 1'b0, 1'b0}};
      vecs[10] = '{OP_SLT, 8'h01,  8'hFF,  '{8'h00,  1'b0, 1'b0, 1'b1}};
      vecs[11] = '{OP_SHL, 8'h81,  8'h0C,  '{8'h10,  1'b0, 1'b0, 1'b0}};
      vecs[12] = '{OP_SHR, 8'h80,  8'h0B,  '{8'h10,  1'b0, 1'b0, 1'b0}};
      vecs[13] = '{OP_MUL, 8'd15,  8'd17,  '{8'd255, 1'b0, 1'b0, 1'b0}};
      vecs[14] = '{OP_MUL, 8'd16,  8'd16,  '{8'd0,   1'b1, 1'b0, 1'b1}};
      vecs[15] = '{OP_MUL, 8'd255, 8'd255, '{8'h01,  1'b1, 1'b0, 1'b0}};
      vecs[16] = '{4'd12,  8'h12,  8'h34,  '{8'd0,   1'b0, 1'b0, 1'b1}};
      vecs[17] = '{4'd9,   8'hFF,  8'hFF,  '{8'd0,   1'b0, 1'b0, 1'b1}};

      // Reset state, then in_ready right after release.
      #3;
      check("reset_outputs", {26'b0, out_valid, busy, carry_flag, overflow_flag, zero_flag,
                              (alu_res != 8'd0)}, 0);
      #19;
      rst = 1'b0;
      #1;
      check("ready_after_reset", {31'b0, in_ready}, 1);
      @(posedge clk);
      #1;
      out_ready = 1'b1;

      // Multiplier disabled: opcode 8 is illegal and completes in one cycle.
      op = OP_MUL;
      num1 = 8'd15;
      num2 = 8'd17;
      in_valid0 = 1'b1;
      @(negedge clk);
      check("nomul_ready", {31'b0, in_ready0}, 1);
      @(posedge clk);
      #1;
      in_valid0 = 1'b0;
      @(negedge clk);
      check("nomul_result", {18'b0, out_valid0, busy0, alu_res0, carry0, ovf0, zero0},
            {18'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
      @(posedge clk);
      #1;

      for (int i = 0; i < 18; i++) send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e, 1'b1);
      drain();

      // Multiply latency and blocking of further requests.
      send(OP_MUL, 8'd15, 8'd17, '{8'd255, 1'b0, 1'b0, 1'b0}, 1'b1);
      edges = 0;
      bad = 0;
      do begin
         @(negedge clk);
         edges++;
         if (!out_valid && (!busy || in_ready)) bad++;
      end while (!out_valid && edges < 50);
      check("mul_latency_edges", edges, WIDTH + 1);
      check("mul_busy_ready", bad, 0);
      drain();

      // Illegal opcode follows the single-cycle handshake.
      send(4'd12, 8'd1, 8'd2, '{8'd0, 1'b0, 1'b0, 1'b1}, 1'b1);
      @(negedge clk);
      check("op12_latency", {30'b0, out_valid, busy}, 2);
      drain();

      // Back-pressure: result held, in_ready low.
      out_ready = 1'b0;
      send(OP_ADD, 8'd10, 8'd20, '{8'd30, 1'b0, 1'b0, 1'b0}, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("hold", {20'b0, out_valid, in_ready, alu_res, carry_flag, overflow_flag, zero_flag},
               {20'b0, 1'b1, 1'b0, 8'd30, 1'b0, 1'b0, 1'b0});
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(OP_ADD, 8'd1,   8'd2,   '{8'd3,   1'b0, 1'b0, 1'b0}, 1'b1);
      send(OP_ADD, 8'd50,  8'd60,  '{8'd110, 1'b0, 1'b0, 1'b0}, 1'b1);
      send(OP_ADD, 8'd100, 8'd100, '{8'd200, 1'b0, 1'b1, 1'b0}, 1'b1);
      send(OP_ADD, 8'd250, 8'd10,  '{8'd4,   1'b1, 1'b0, 1'b0}, 1'b1);
      drain();
      np = pop_cyc.size();
      check("b2b_consecutive", pop_cyc[np-1] - pop_cyc[np-4], 3);

      // Reset during the fourth multiply step aborts with no result.
      send(OP_MUL, 8'd15, 8'd17, '{8'd255, 1'b0, 1'b0, 1'b0}, 1'b0);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("reset_mid_mul", {18'b0, out_valid, busy, alu_res, carry_flag, overflow_flag,
                              zero_flag}, 0);
      @(negedge clk);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("ready_after_abort", {31'b0, in_ready}, 1);
      send(OP_ADD, 8'd1, 8'd1, '{8'd2, 1'b0, 1'b0, 1'b0}, 1'b1);
      drain();
      repeat (12) @(negedge clk);
      check("no_stale_product", {31'b0, out_valid}, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, registered-output ALU with valid/ready handshakes on both sides. It supports eight single-cycle operations plus an optional multi-cycle shift-add multiply. It produces zero/carry/overflow flags and sits between the decode/operand-fetch stage and the write-back stage of the datapath. It replaces the fixed 8-bit add-only ALU as the execute unit.

## Interface
- WIDTH, 8, operand/result width (≥2)
- MUL_EN, 1, 1 enables MUL opcode; 0 makes opcode 8 illegal
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  ALU can accept a request this cycle
- op  in  4  opcode (see Operation)
- num1  in  WIDTH  operand A
- num2  in  WIDTH  operand B / immediate / shift amount
- out_valid  out  1  result registers hold an unconsumed result
- out_ready  in  1  consumer takes result this cycle
- alu_res  out  WIDTH  result
- zero_flag  out  1  1 when alu_res == 0
- carry_flag  out  1  carry/borrow/multiply-overflow
- overflow_flag  out  1  signed overflow (ADD/SUB only)
- busy  out  1  multiply in progress

## Operation
- Opcodes:
  - 0 ADD: A+B; carry = bit WIDTH of sum; overflow = signed overflow.
  - 1 SUB: A−B; carry = borrow (A<B unsigned); overflow = signed overflow.
  - 2 AND, 3 OR, 4 XOR: bitwise.
  - 5 SLT: 1 if A<B signed, else 0.
  - 6 SHL, 7 SHR (logical): shift amount = num2[$clog2(WIDTH)-1:0].
  - 8 MUL: low WIDTH bits of A×B unsigned; carry = 1 if any upper product bit is nonzero.
  - Illegal (9–15, or 8 with MUL_EN=0): res 0, carry 0, overflow 0.
- carry/overflow are 0 for any op not listed with them; zero_flag is always derived from the registered alu_res.
- Accept = in_valid && in_ready; operands and op are captured on the accept edge.
- in_ready = (state==IDLE) && (!out_valid || out_ready); combinational.
- States:
  - IDLE: on accept of a non-MUL op, load result/flags and set out_valid. On accept of MUL, load multiplicand/multiplier, clear accumulator, counter=0, go to MUL.
  - MUL: one shift-add step per cycle, WIDTH steps. After the last step, load result/flags, set out_valid, return to IDLE. busy=1 only in MUL.
- out_valid clears on out_ready when no new result loads the same edge. Accept and consume on the same edge replace the result, and out_valid stays 1.
- Results and flags hold stable while out_valid && !out_ready.

## Timing
- Reset (async, immediate): state IDLE, out_valid 0, alu_res 0, zero_flag 0, carry_flag 0, overflow_flag 0, busy 0, counter 0.
- in_ready is 1 in the first cycle after rst deasserts.
- Reset asserted mid-multiply aborts it; no result is ever presented for the aborted request.
- Single-cycle ops: accept at edge T, out_valid=1 after T; sustained throughput is 1 per cycle with out_ready held high.
- MUL: accept at edge T, out_valid rises after edge T+WIDTH. Latency is WIDTH+1 edges, and in_ready=0 from T until the result is loaded.
- MUL and the following op cannot overlap: the next accept occurs no earlier than the edge on which the MUL result is consumed.
- No combinational path from num1/num2/op to any output; in_ready depends only on state, out_valid and out_ready.

## Test plan
- ADD 200+100 (WIDTH=8) -> alu_res 44, carry 1, overflow 0, zero 0. ADD 127+1 -> 128, carry 0, overflow 1.
- SUB 5−5 -> 0, zero 1, carry 0. SUB 3−5 -> 254, carry 1, overflow 0. SLT 0xFF,0x01 -> 1. SHR 0x80 by num2=0x0B (amount 3) -> 0x10.
- MUL 15×17 -> 255, carry 0, out_valid exactly 9 edges after accept, busy/in_ready=0 throughout. MUL 16×16 -> res 0, carry 1, zero 1. MUL_EN=0, op 8 -> res 0, flags 0, zero 1, 1-cycle latency.
- Back-pressure: result valid, out_ready low 3 cycles -> alu_res/flags unchanged, in_ready 0. Then out_ready high with 4 back-to-back ADDs -> 4 results on 4 consecutive cycles, in order.
- Reset at cycle 4 of a MUL -> out_valid 0, busy 0, all outputs 0 immediately; after release in_ready 1, and the next ADD 1+1 returns 2 with no stale product.
- Opcode 12 -> res 0, zero 1, carry 0, overflow 0, handshake identical to ADD.
